mcpu_run_monitor: RTL and testbench

- Synthesizable run controller and trace monitor for MCPU simulation and bring-up.
- Sequences core reset, counts run cycles, and detects completion or timeout.
- Timestamps changes on NUM_CH memory-output channels into a trace FIFO that a host or bench drains over a valid/ready port.
- Replaces ad-hoc free-running clock/reset/display logic with a parametrised, checkable block.

---
 rtl/mcpu_run_monitor_if.sv | 33 +++
 rtl/mcpu_run_monitor.sv | 182 ++++++++++++++++++
 tb/tb_mcpu_run_monitor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_run_monitor_if.sv
// Trace/monitor bundle for mcpu_run_monitor.
//   mon_data    : NUM_CH packed monitored channels, channel i at [i*DATA_W +: DATA_W]
//   trace_valid : trace FIFO non-empty
//   trace_ready : consumer accepts the head entry
//   trace_data  : head entry {cycle, channel, data}
// master = the monitor, slave = the trace consumer / stimulus source.
interface mcpu_run_monitor_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 24
);
    localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TraceW = CNT_W + ChW + DATA_W;

    logic [NUM_CH*DATA_W-1:0] mon_data;
    logic                     trace_valid;
    logic                     trace_ready;
    logic [TraceW-1:0]        trace_data;

    modport master (
        input  mon_data,
        input  trace_ready,
        output trace_valid,
        output trace_data
    );

    modport slave (
        output mon_data,
        output trace_ready,
        input  trace_valid,
        input  trace_data
    );
endinterface

// File: rtl/mcpu_run_monitor.sv
// Run controller and trace monitor for MCPU bring-up.
// Holds the core in reset for RESET_CYCLES, counts run cycles, ends the run on
// DONE_VALUE at channel 0 or on MAX_CYCLES, and timestamps channel changes into
// a trace FIFO drained over a valid/ready port.
//   clkrst_core_clk : core clock
//   clkrst_core_rst : asynchronous active-high reset
//   mon_if          : monitored channels in, trace FIFO out (master side)
//   core_rst_n      : registered active-low core reset
//   run_cycle       : cycles spent in RUN (saturating)
//   done/timeout    : sticky run outcome
//   overflow        : sticky, a trace entry was dropped on a full FIFO
//   collision       : sticky, several channels changed in one cycle
module mcpu_run_monitor #(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       NUM_CH       = 2,
    parameter int unsigned       DEPTH        = 16,
    parameter int unsigned       CNT_W        = 24,
    parameter int unsigned       RESET_CYCLES = 5,
    parameter int unsigned       MAX_CYCLES   = 10000,
    parameter logic [DATA_W-1:0] DONE_VALUE   = DATA_W'(32'hD0D0D0D0)
) (
    input  logic                clkrst_core_clk,
    input  logic                clkrst_core_rst,
    mcpu_run_monitor_if.master  mon_if,
    output logic                core_rst_n,
    output logic [CNT_W-1:0]    run_cycle,
    output logic                done,
    output logic                timeout,
    output logic                overflow,
    output logic                collision
);
    localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned EntryW = CNT_W + ChW + DATA_W;
    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned HoldW  = $clog2(RESET_CYCLES + 1);
    // Only meaningful when MAX_CYCLES != 0; the comparison is gated on that.
    localparam logic [CNT_W-1:0] MaxCyclesM1 = CNT_W'(MAX_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast    = HoldW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {StHold, StRun, StDone, StTimeout} state_e;

    state_e                   state_q, state_d;
    logic [HoldW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]         run_cycle_q, run_cycle_d;
    logic                     core_rst_n_q, core_rst_n_d;
    logic                     done_q, done_d;
    logic                     timeout_q, timeout_d;
    logic                     overflow_q, overflow_d;
    logic                     collision_q, collision_d;
    logic [NUM_CH*DATA_W-1:0] prev_q, prev_d;
    logic [PtrW:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]            rd_ptr_q, rd_ptr_d;
    logic [EntryW-1:0]        mem_q [DEPTH];

    logic              in_run;
    logic              any_change;
    logic              multi_change;
    logic [ChW-1:0]    sel_idx;
    logic [DATA_W-1:0] sel_data;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              empty;
    logic              full;
    logic [EntryW-1:0] push_data;

    assign in_run = (state_q == StRun);

    // Lowest-index changed channel wins; any further change flags a collision.
    always_comb begin
        any_change   = 1'b0;
        multi_change = 1'b0;
        sel_idx      = '0;
        sel_data     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (mon_if.mon_data[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]) begin
                if (any_change) begin
                    multi_change = 1'b1;
                end else begin
                    any_change = 1'b1;
                    sel_idx    = ChW'(i);
                    sel_data   = mon_if.mon_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign push_req  = in_run && any_change;
    assign push_data = {run_cycle_q, sel_idx, sel_data};

    // Extra pointer bit distinguishes full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop     = !empty && mon_if.trace_ready;
    assign push_ok = push_req && (!full || pop);

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        run_cycle_d = run_cycle_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            StHold: begin
                hold_cnt_d = hold_cnt_q + HoldW'(1);
                if (hold_cnt_q == HoldLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (run_cycle_q != '1) begin
                    run_cycle_d = run_cycle_q + CNT_W'(1);
                end
                if (mon_if.mon_data[DATA_W-1:0] == DONE_VALUE) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if ((MAX_CYCLES != 0) && (run_cycle_q == MaxCyclesM1)) begin
                    state_d   = StTimeout;
                    timeout_d = 1'b1;
                end
            end
            StDone, StTimeout: begin
            end
            default: begin
            end
        endcase
        core_rst_n_d = (state_d == StRun);
    end

    always_comb begin
        prev_d      = mon_if.mon_data;
        wr_ptr_d    = push_ok ? wr_ptr_q + (PtrW+1)'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + (PtrW+1)'(1) : rd_ptr_q;
        overflow_d  = overflow_q || (push_req && !push_ok);
        collision_d = collision_q || (in_run && multi_change);
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q      <= StHold;
            hold_cnt_q   <= '0;
            run_cycle_q  <= '0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overflow_q   <= 1'b0;
            collision_q  <= 1'b0;
            prev_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            run_cycle_q  <= run_cycle_d;
            core_rst_n_q <= core_rst_n_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            overflow_q   <= overflow_d;
            collision_q  <= collision_d;
            prev_q       <= prev_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge clkrst_core_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
        end
    end

    assign mon_if.trace_valid = !empty;
    assign mon_if.trace_data  = empty ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];
    assign core_rst_n         = core_rst_n_q;
    assign run_cycle          = run_cycle_q;
    assign done               = done_q;
    assign timeout            = timeout_q;
    assign overflow           = overflow_q;
    assign collision          = collision_q;
endmodule

// File: tb/tb_mcpu_run_monitor.sv
// Directed bench for mcpu_run_monitor (DEPTH=4, MAX_CYCLES=20).
// Cycle 0 is the cycle in which reset is released; inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_mcpu_run_monitor;
    localparam int unsigned DataW = 32;
    localparam int unsigned NumCh = 2;
    localparam int unsigned CntW  = 24;
    localparam int unsigned EntW  = CntW + 1 + DataW;

    logic            clk;
    logic            rst;
    logic            core_rst_n;
    logic [CntW-1:0] run_cycle;
    logic            done;
    logic            timeout;
    logic            overflow;
    logic            collision;

    int checks   = 0;
    int failures = 0;

    mcpu_run_monitor_if #(.DATA_W(DataW), .NUM_CH(NumCh), .CNT_W(CntW)) mon_if ();

    mcpu_run_monitor #(
        .DATA_W      (DataW),
        .NUM_CH      (NumCh),
        .DEPTH       (4),
        .CNT_W       (CntW),
        .RESET_CYCLES(5),
        .MAX_CYCLES  (20),
        .DONE_VALUE  (32'hD0D0D0D0)
    ) dut (
        .clkrst_core_clk(clk),
        .clkrst_core_rst(rst),
        .mon_if         (mon_if.master),
        .core_rst_n     (core_rst_n),
        .run_cycle      (run_cycle),
        .done           (done),
        .timeout        (timeout),
        .overflow       (overflow),
        .collision      (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     m0;
        logic [31:0]     m1;
        logic            rdy;
        logic            e_crn;
        int unsigned     e_rc;
        logic            e_vld;
        logic [EntW-1:0] e_dat;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [EntW-1:0] ent(input int unsigned c, input int unsigned ch,
                                            input logic [31:0] d);
        return {c[CntW-1:0], ch[0], d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] m0, input logic [31:0] m1, input logic rdy);
        mon_if.mon_data    = {m1, m0};
        mon_if.trace_ready = rdy;
    endtask

    // Returns at cycle 0 with reset just released.
    task automatic do_reset();
        rst = 1'b1;
        drive(32'd0, 32'd0, 1'b0);
        tick();
        tick();
        check("rst_crn", core_rst_n, 0);
        check("rst_vld", mon_if.trace_valid, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'd0, 32'd0, 1'b0);

        // Table: reset sequencing then channel 0 = 1,2,3 on run cycles 0..2.
        for (int c = 0; c < 5; c++) vecs[c] = '{32'd0, 32'd0, 1'b1, 1'b0, 0, 1'b0, '0};
        vecs[5]  = '{32'd1, 32'd0, 1'b1, 1'b1, 0, 1'b0, '0};
        vecs[6]  = '{32'd2, 32'd0, 1'b1, 1'b1, 1, 1'b1, ent(0, 0, 32'd1)};
        vecs[7]  = '{32'd3, 32'd0, 1'b1, 1'b1, 2, 1'b1, ent(1, 0, 32'd2)};
        vecs[8]  = '{32'd3, 32'd0, 1'b1, 1'b1, 3, 1'b1, ent(2, 0, 32'd3)};
        vecs[9]  = '{32'd3, 32'd0, 1'b1, 1'b1, 4, 1'b0, '0};
        vecs[10] = '{32'd3, 32'd0, 1'b1, 1'b1, 5, 1'b0, '0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].m0, vecs[i].m1, vecs[i].rdy);
            check($sformatf("v%0d_crn", i), core_rst_n, vecs[i].e_crn);
            check($sformatf("v%0d_rc", i), run_cycle, vecs[i].e_rc);
            check($sformatf("v%0d_vld", i), mon_if.trace_valid, vecs[i].e_vld);
            if (vecs[i].e_vld) check($sformatf("v%0d_dat", i), mon_if.trace_data, vecs[i].e_dat);
            check($sformatf("v%0d_ovf", i), overflow, 0);
            check($sformatf("v%0d_done", i), done, 0);
            tick();
        end

        // Timeout after run cycle 19 (cycle 24).
        do_reset();
        drive(32'd0, 32'd0, 1'b1);
        repeat (24) tick();
        check("to_rc19", run_cycle, 19);
        check("to_crn_hi", core_rst_n, 1);
        check("to_pre", timeout, 0);
        tick();
        check("to_set", timeout, 1);
        check("to_crn_lo", core_rst_n, 0);
        check("to_rc20", run_cycle, 20);
        check("to_done", done, 0);
        repeat (3) tick();
        check("to_frozen", run_cycle, 20);
        check("to_sticky", timeout, 1);

        // Done value on run cycle 7 (cycle 12).
        do_reset();
        drive(32'd0, 32'd0, 1'b1);
        repeat (12) tick();
        check("dn_rc7", run_cycle, 7);
        drive(32'hD0D0D0D0, 32'd0, 1'b1);
        tick();
        check("dn_done", done, 1);
        check("dn_crn", core_rst_n, 0);
        check("dn_rc", run_cycle, 8);
        check("dn_vld", mon_if.trace_valid, 1);
        check("dn_dat", mon_if.trace_data, ent(7, 0, 32'hD0D0D0D0));
        drive(32'd5, 32'd9, 1'b1);
        tick();
        check("dn_nomore", mon_if.trace_valid, 0);
        repeat (14) tick();
        check("dn_nomore2", mon_if.trace_valid, 0);
        check("dn_frozen", run_cycle, 8);
        check("dn_noto", timeout, 0);

        // Overflow: channel 1 changes on run cycles 0..5 with ready low.
        do_reset();
        repeat (5) tick();
        for (int k = 0; k < 6; k++) begin
            drive(32'd0, 32'(k + 1), 1'b0);
            check($sformatf("of_ovf%0d", k), overflow, (k == 5) ? 1 : 0);
            tick();
        end
        check("of_sticky", overflow, 1);
        drive(32'd0, 32'd6, 1'b1);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("of_vld%0d", j), mon_if.trace_valid, 1);
            check($sformatf("of_dat%0d", j), mon_if.trace_data, ent(j, 1, 32'(j + 1)));
            tick();
        end
        check("of_empty", mon_if.trace_valid, 0);
        check("of_col", collision, 0);

        // Collision on run cycle 3 (cycle 8), then asynchronous reset in cycle 10.
        do_reset();
        repeat (8) tick();
        check("col_pre", collision, 0);
        drive(32'h0000000A, 32'h0000000B, 1'b0);
        tick();
        check("col_set", collision, 1);
        check("col_vld", mon_if.trace_valid, 1);
        check("col_dat", mon_if.trace_data, ent(3, 0, 32'h0000000A));
        drive(32'h0000000C, 32'h0000000B, 1'b1);
        tick();
        // A lost channel-1 entry would sit at the head here instead.
        check("col_head", mon_if.trace_data, ent(4, 0, 32'h0000000C));
        check("col_rc", run_cycle, 5);
        drive(32'h0000000C, 32'h0000000B, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_crn", core_rst_n, 0);
        check("ar_rc", run_cycle, 0);
        check("ar_vld", mon_if.trace_valid, 0);
        check("ar_dat", mon_if.trace_data, 0);
        check("ar_col", collision, 0);
        check("ar_done", done, 0);
        check("ar_to", timeout, 0);
        check("ar_ovf", overflow, 0);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
